dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the target side of the CPU's load/store interface (addr, wrData, wrMem, rdMem, rdData).
- Adds a ready handshake so the control unit can stall on wait states.
- Accepts one word request at a time, waits LATENCY cycles, then commits or returns data.
- Sits between the datapath ALU result / rt read port and the writeback mux.

---
 rtl/dmem_responder_pkg.sv | 21 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared types and constants for the data-memory responder and the CPU-side
//   stall logic that waits on its ready handshake.
//   No ports (package).

package dmem_responder_pkg;

   localparam int unsigned LAT_MAX    = 15;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 10;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   typedef enum logic [1:0] {OP_RD, OP_WR, OP_BAD} op_e;

   // Wait-state count actually used by the hardware (4-bit counter).
   function automatic int unsigned clamp_lat(input int unsigned lat);
      return (lat > LAT_MAX) ? LAT_MAX : lat;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
//   Synchronous single-port RAM, read-first, no reset (contents survive reset).
//   Ports:
//     clk   rising-edge clock
//     we    write enable
//     addr  word address
//     din   write data
//     dout  registered read data of the word addressed on the previous edge

module dmem_array #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
      dout <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Target side of the CPU load/store interface. Accepts one word request at a
//   time, waits LATENCY cycles, then commits the store or returns load data
//   with a one-cycle ready pulse. rdMem and wrMem together are rejected with err.
//   Optional build macro DMEM_RANGE_CHECK_EN: addresses with bits above ADDR_W
//   set are rejected with err instead of wrapping modulo the depth.
//   Ports:
//     clk     rising-edge clock
//     rst     asynchronous active-low reset
//     addr    word address, held by the initiator until ready
//     wrData  store data, held with addr
//     wrMem   store request level
//     rdMem   load request level
//     rdData  load result, valid in the ready cycle and held afterwards
//     ready   one-cycle completion pulse
//     err     one-cycle error pulse, coincident with ready
//     busy    high from the cycle after acceptance through the ready cycle

module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wrData,
   input  logic              wrMem,
   input  logic              rdMem,
   output logic [DATA_W-1:0] rdData,
   output logic              ready,
   output logic              err,
   output logic              busy
);

   localparam int unsigned LAT     = clamp_lat(LATENCY);
   localparam logic [3:0]  LAT_CNT = 4'(LAT);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   op_e               req_op;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_dout;

   // Decode the incoming request; anything that must not touch the array
   // collapses into OP_BAD so the response path only has one error case.
   always_comb begin
      req_op = OP_BAD;
      if (rdMem && !wrMem) begin
         req_op = OP_RD;
      end else if (wrMem && !rdMem) begin
         req_op = OP_WR;
      end
`ifdef DMEM_RANGE_CHECK_EN
      if (|addr[31:ADDR_W]) begin
         req_op = OP_BAD;
      end
`endif
   end

`ifndef DMEM_RANGE_CHECK_EN
   // High address bits wrap modulo depth.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[31:ADDR_W];
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (rdMem || wrMem) begin
               op_d    = req_op;
               addr_d  = addr[ADDR_W-1:0];
               wdata_d = wrData;
               cnt_d   = LAT_CNT;
               state_d = (LAT == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            // Leaving RESP always passes through IDLE, so a request still held
            // during the ready cycle is never sampled twice.
            state_d = IDLE;
            if (op_q == OP_RD) begin
               rdata_d = ram_dout;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q    <= OP_RD;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // In IDLE the RAM reads the live address so that a zero-latency load has
   // its word ready in the RESP cycle; afterwards it tracks the latched one.
   assign ram_addr = (state_q == IDLE) ? addr[ADDR_W-1:0] : addr_q;
   assign ram_we   = (state_q == RESP) && (op_q == OP_WR);

   dmem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk  (clk),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (wdata_q),
      .dout (ram_dout)
   );

   assign ready  = (state_q == RESP);
   assign err    = ready && (op_q == OP_BAD);
   assign busy   = (state_q != IDLE);
   assign rdData = (ready && (op_q == OP_RD)) ? ram_dout : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Two responders share clock and reset: dut2 with LATENCY=2, dut0 with
//   LATENCY=0. Expected responses are queued when a request is driven and
//   popped when ready is seen.

module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;

   logic [31:0] addr2, wdata2, rdata2;
   logic        rd2, wr2, ready2, err2, busy2;
   logic [31:0] addr0, wdata0, rdata0;
   logic        rd0, wr0, ready0, err0, busy0;

   dmem_responder #(
      .DATA_W  (32),
      .ADDR_W  (10),
      .LATENCY (2)
   ) dut2 (
      .clk    (clk),
      .rst    (rst),
      .addr   (addr2),
      .wrData (wdata2),
      .wrMem  (wr2),
      .rdMem  (rd2),
      .rdData (rdata2),
      .ready  (ready2),
      .err    (err2),
      .busy   (busy2)
   );

   dmem_responder #(
      .DATA_W  (32),
      .ADDR_W  (10),
      .LATENCY (0)
   ) dut0 (
      .clk    (clk),
      .rst    (rst),
      .addr   (addr0),
      .wrData (wdata0),
      .wrMem  (wr0),
      .rdMem  (rd0),
      .rdData (rdata0),
      .ready  (ready0),
      .err    (err0),
      .busy   (busy0)
   );

`ifdef DMEM_RANGE_CHECK_EN
   localparam logic        RC_ERR  = 1'b1;
   localparam logic [31:0] RC_RD0  = 32'h1111_0000;
`else
   localparam logic        RC_ERR  = 1'b0;
   localparam logic [31:0] RC_RD0  = 32'h0000_0003;
`endif

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
      logic        e_err;
      logic [31:0] e_rdata;
   } vec_t;

   typedef struct {
      int          lat;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic drive(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel) begin
         rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d;
      end else begin
         rd2 = rd; wr2 = wr; addr2 = a; wdata2 = d;
      end
   endtask

   // One full transaction: drive, wait (bounded) for ready, compare against
   // the queued expectation, drop the request and check the gap cycle.
   task automatic xact(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rdata, input string name);
      exp_t e;
      exp_t got;
      int   cyc;
      logic rdy;
      e.lat   = sel ? 1 : 3;
      e.err   = e_err;
      e.rdata = e_rdata;
      sb.push_back(e);
      drive(sel, rd, wr, a, d);
      @(posedge clk);
      cyc = 0;
      rdy = 1'b0;
      while (!rdy && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check({name, " busy"}, 32'(sel ? busy0 : busy2), 32'd1);
         rdy = sel ? ready0 : ready2;
      end
      got = sb.pop_front();
      check({name, " latency"}, 32'(cyc), 32'(got.lat));
      check({name, " err"}, 32'(sel ? err0 : err2), 32'(got.err));
      check({name, " rdData"}, sel ? rdata0 : rdata2, got.rdata);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check({name, " gap rdy/err/busy"},
            32'(sel ? {ready0, err0, busy0} : {ready2, err2, busy2}), 32'd0);
      check({name, " rdData held"}, sel ? rdata0 : rdata2, got.rdata);
   endtask

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 32'd5,     32'hDEAD_BEEF, 1'b0,   32'h0000_0000};
      tbl[1]  = '{1'b1, 1'b0, 32'd5,     32'h0,         1'b0,   32'hDEAD_BEEF};
      tbl[2]  = '{1'b0, 1'b1, 32'd3,     32'h1234_5678, 1'b0,   32'hDEAD_BEEF};
      tbl[3]  = '{1'b1, 1'b1, 32'd3,     32'hFFFF_FFFF, 1'b1,   32'hDEAD_BEEF};
      tbl[4]  = '{1'b1, 1'b0, 32'd3,     32'h0,         1'b0,   32'h1234_5678};
      tbl[5]  = '{1'b0, 1'b1, 32'd9,     32'hA5A5_0009, 1'b0,   32'h1234_5678};
      tbl[6]  = '{1'b0, 1'b1, 32'd0,     32'h1111_0000, 1'b0,   32'h1234_5678};
      tbl[7]  = '{1'b0, 1'b1, 32'h3FF,   32'hCAFE_F00D, 1'b0,   32'h1234_5678};
      tbl[8]  = '{1'b1, 1'b0, 32'h3FF,   32'h0,         1'b0,   32'hCAFE_F00D};
      tbl[9]  = '{1'b0, 1'b1, 32'h400,   32'h0000_0003, RC_ERR, 32'hCAFE_F00D};
      tbl[10] = '{1'b1, 1'b0, 32'd0,     32'h0,         1'b0,   RC_RD0};

      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Reset state of both instances, then a quiet idle stretch.
      @(negedge clk);
      check("reset ready2", 32'(ready2), 32'd0);
      check("reset err2", 32'(err2), 32'd0);
      check("reset busy2", 32'(busy2), 32'd0);
      check("reset rdData2", rdata2, 32'h0);
      check("reset ready0", 32'(ready0), 32'd0);
      check("reset err0", 32'(err0), 32'd0);
      check("reset busy0", 32'(busy0), 32'd0);
      check("reset rdData0", rdata0, 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle rdy/err/busy", 32'({ready2, err2, busy2, ready0, err0, busy0}), 32'd0);
      end

      for (int i = 0; i < 11; i++) begin
         xact(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d,
              tbl[i].e_err, tbl[i].e_rdata, $sformatf("vec%0d", i));
      end

      // Reset in the middle of a store's wait states.
      drive(1'b0, 1'b0, 1'b1, 32'd9, 32'h0000_0001);
      @(posedge clk);
      @(negedge clk);
      check("midrst busy before", 32'(busy2), 32'd1);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("midrst no ready", 32'({ready2, err2, busy2}), 32'd0);
      end
      check("midrst rdData cleared", rdata2, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      xact(1'b0, 1'b1, 1'b0, 32'd9, 32'h0, 1'b0, 32'hA5A5_0009, "midrst load9");

      // Zero latency back-to-back: store then load of the same word.
      xact(1'b1, 1'b0, 1'b1, 32'd1, 32'd7, 1'b0, 32'h0, "lat0 store");
      xact(1'b1, 1'b1, 1'b0, 32'd1, 32'h0, 1'b0, 32'd7, "lat0 load");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("lat0 no reaccept", 32'({ready0, err0, busy0}), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
